// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite signal bundle between one master and one SRAM slave.
// The master modport drives address/control/write data. The slave modport
// returns read data, ready and response.
interface ahb_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [5:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic [2:0]            HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave.
// - Pipelined address and data phases, with WAIT_STATES ready-low cycles.
// - Byte-lane writes go through a one-entry write buffer.
// - Read-after-write forwarding from that buffer.
// Optional macro AHB_LITE_SRAM_ERR_EN: illegal transfers get a two-cycle ERROR
// response. When it is undefined, illegal transfers complete OKAY: the write
// is dropped and the read returns zero.
module ahb_lite_sram_slave #(
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int AHB_DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS     = 10,
  parameter int WAIT_STATES       = 0
) (
  input  logic       clk,
  input  logic       rst,
  ahb_lite_if.slave  bus
);

  localparam int LB        = (AHB_DATA_WIDTH == 64) ? 3 : 2;
  localparam int NB        = AHB_DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << MEM_ADDR_BITS;
  localparam int SPAN_BITS = MEM_ADDR_BITS + LB;
  localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef logic [AHB_ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [AHB_DATA_WIDTH-1:0]    data_t;
  typedef logic [MEM_ADDR_BITS-1:0]     idx_t;
  typedef logic [NB-1:0]                be_t;

`ifdef AHB_LITE_SRAM_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_e;
`endif

  // Overlay the enabled bytes of upd onto base.
  function automatic data_t merge_bytes(data_t base, data_t upd, be_t be);
    data_t r = base;
    for (int b = 0; b < NB; b++)
      if (be[b]) r[8*b +: 8] = upd[8*b +: 8];
    return r;
  endfunction

  state_e state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;

  // Address-phase attributes, held for the data phase.
  logic dp_write_q, dp_legal_q;
  idx_t dp_idx_q;
  be_t  dp_be_q;

  // One-entry write buffer.
  logic  wb_valid_q;
  idx_t  wb_idx_q;
  be_t   wb_be_q;
  data_t wb_data_q;

  data_t rd_data_q;
  data_t mem [DEPTH];

  addr_t haddr;
  logic  hready, hresp_err;
  logic  accept, req_legal;
  idx_t  req_idx;
  be_t   req_be;
  logic  sram_rd, wb_load, wb_commit, rd_pending, rd_dphase;

  assign haddr   = bus.HADDR;
  assign accept  = bus.HSEL && bus.HTRANS[1] && hready;
  assign req_idx = haddr[SPAN_BITS-1:LB];

  // Decode legality and byte-lane enables of the current address phase.
  always_comb begin
    logic [2:0] align_mask;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    align_mask = 3'b000;
    req_be     = '0;
    case (bus.HSIZE)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    req_legal = (bus.HSIZE <= 3'(LB))
             && ((haddr[2:0] & align_mask) == 3'b000)
             && ((haddr >> SPAN_BITS) == '0);
    for (int b = 0; b < NB; b++)
      req_be[b] = (b >= int'(haddr[LB-1:0]))
               && (b < int'(haddr[LB-1:0]) + (1 << bus.HSIZE));
  end

  // A read goes to the SRAM on its accept edge. The buffer drains on any edge
  // without a read. When a second write lands, the buffer drains on that edge
  // even if a read is also issued.
  assign sram_rd    = accept && !bus.HWRITE && req_legal;
  assign wb_load    = (state_q == S_DATA) && dp_write_q && dp_legal_q;
  assign wb_commit  = wb_valid_q && (!sram_rd || wb_load);
  assign rd_pending = ((state_q == S_WAIT) || (state_q == S_DATA)) && !dp_write_q && dp_legal_q;
  assign rd_dphase  = (state_q == S_DATA) && !dp_write_q && dp_legal_q;

  // State register and wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic: accept into WAIT/DATA (or ERR1), count waits, go idle.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_DATA;
        else              wcnt_d  = wcnt_q - 4'd1;
      end
`ifdef AHB_LITE_SRAM_ERR_EN
      S_ERR1: state_d = S_ERR2;
`endif
      default: begin
        if (accept) begin
`ifdef AHB_LITE_SRAM_ERR_EN
          if (!req_legal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WS_INIT;
          end else begin
            state_d = S_DATA;
          end
`else
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WS_INIT;
          end else begin
            state_d = S_DATA;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // HREADY and ERROR flag from the current state.
  always_comb begin
    hready    = 1'b1;
    hresp_err = 1'b0;
    case (state_q)
      S_WAIT: hready = 1'b0;
`ifdef AHB_LITE_SRAM_ERR_EN
      S_ERR1: begin
        hready    = 1'b0;
        hresp_err = 1'b1;
      end
      S_ERR2: hresp_err = 1'b1;
`endif
      default: ;
    endcase
  end

  // Latch address-phase attributes on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_write_q <= 1'b0;
      dp_legal_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_be_q    <= '0;
    end else if (accept) begin
      dp_write_q <= bus.HWRITE;
      dp_legal_q <= req_legal;
      dp_idx_q   <= req_idx;
      dp_be_q    <= req_be;
    end
  end

  // Capture write data into the buffer at data-phase completion; clear on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_be_q    <= '0;
      wb_data_q  <= '0;
    end else if (wb_load) begin
      wb_valid_q <= 1'b1;
      wb_idx_q   <= dp_idx_q;
      wb_be_q    <= dp_be_q;
      wb_data_q  <= bus.HWDATA;
    end else if (wb_commit) begin
      wb_valid_q <= 1'b0;
    end
  end

  // Read register. A buffer drain to the same word, on the issue edge or during
  // waits, is folded in, so the SRAM copy never goes stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (sram_rd) begin
      if (wb_commit && (wb_idx_q == req_idx))
        rd_data_q <= merge_bytes(mem[req_idx], wb_data_q, wb_be_q);
      else
        rd_data_q <= mem[req_idx];
    end else if (rd_pending && wb_commit && (wb_idx_q == dp_idx_q)) begin
      rd_data_q <= merge_bytes(rd_data_q, wb_data_q, wb_be_q);
    end
  end

  // SRAM byte-lane write from the draining buffer.
  always_ff @(posedge clk) begin
    // NOTE: the SRAM array has no reset; its contents survive rst and it maps onto a plain RAM macro.
    if (wb_commit)
      for (int b = 0; b < NB; b++)
        if (wb_be_q[b]) mem[wb_idx_q][8*b +: 8] <= wb_data_q[8*b +: 8];
  end

  assign bus.HREADY = hready;
  assign bus.HRDATA = rd_dphase
                    ? ((wb_valid_q && (wb_idx_q == dp_idx_q))
                       ? merge_bytes(rd_data_q, wb_data_q, wb_be_q) : rd_data_q)
                    : '0;
`ifdef AHB_LITE_SRAM_ERR_EN
  assign bus.HRESP = {2'b00, hresp_err};
`else
  assign bus.HRESP = 3'b000;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0], hresp_err};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave. It drives three instances (0, 2 and 3
// wait states) from one stimulus set; only the active instance sees HSEL.
module tb_ahb_lite_sram_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int act    = 0;

  logic        hsel_d   = 1'b0;
  logic [31:0] haddr_d  = '0;
  logic [1:0]  htrans_d = 2'b00;
  logic        hwrite_d = 1'b0;
  logic [2:0]  hsize_d  = 3'd2;
  logic [31:0] hwdata_d = '0;

  logic        hready_o;
  logic [2:0]  hresp_o;
  logic [31:0] hrdata_o;

  ahb_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  ahb_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();
  ahb_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

  assign if0.HSEL = hsel_d && (act == 0);
  assign if2.HSEL = hsel_d && (act == 2);
  assign if3.HSEL = hsel_d && (act == 3);
  assign if0.HADDR = haddr_d;  assign if2.HADDR = haddr_d;  assign if3.HADDR = haddr_d;
  assign if0.HTRANS = htrans_d; assign if2.HTRANS = htrans_d; assign if3.HTRANS = htrans_d;
  assign if0.HWRITE = hwrite_d; assign if2.HWRITE = hwrite_d; assign if3.HWRITE = hwrite_d;
  assign if0.HSIZE = hsize_d;  assign if2.HSIZE = hsize_d;  assign if3.HSIZE = hsize_d;
  assign if0.HBURST = 3'd0;    assign if2.HBURST = 3'd0;    assign if3.HBURST = 3'd0;
  assign if0.HPROT = 6'd0;     assign if2.HPROT = 6'd0;     assign if3.HPROT = 6'd0;
  assign if0.HWDATA = hwdata_d; assign if2.HWDATA = hwdata_d; assign if3.HWDATA = hwdata_d;

  ahb_lite_sram_slave #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  ahb_lite_sram_slave #(.WAIT_STATES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  ahb_lite_sram_slave #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  always_comb begin
    case (act)
      0: begin hready_o = if0.HREADY; hresp_o = if0.HRESP; hrdata_o = if0.HRDATA; end
      2: begin hready_o = if2.HREADY; hresp_o = if2.HRESP; hrdata_o = if2.HRDATA; end
      default: begin hready_o = if3.HREADY; hresp_o = if3.HRESP; hrdata_o = if3.HRDATA; end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel_d = 1'b1; htrans_d = 2'b10; haddr_d = a; hwrite_d = w; hsize_d = sz;
  endtask

  task automatic drive_idle();
    hsel_d = 1'b0; htrans_d = 2'b00;
  endtask

  task automatic wait_ready(output int waits);
    waits = 0;
    while (hready_o !== 1'b1 && waits < 20) begin
      step();
      waits++;
    end
    if (hready_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: HREADY=%b after %0d cycles, need 1", hready_o, waits);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int w;
    drive_addr(a, 1'b1, sz);
    step();
    drive_idle();
    hwdata_d = d;
    wait_ready(w);
    step();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz,
                         output logic [31:0] d, output logic [2:0] r, output int waits);
    drive_addr(a, 1'b0, sz);
    step();
    drive_idle();
    wait_ready(waits);
    d = hrdata_o;
    r = hresp_o;
    step();
  endtask

  task automatic test_reset();
    act = 0;
    drive_idle();
    #1;
    checks++; if (hready_o !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b need 1", hready_o); end
    checks++; if (hresp_o !== 3'd0) begin errors++; $display("FAIL reset_hresp: got %0d need 0", hresp_o); end
    checks++; if (hrdata_o !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h need 0", hrdata_o); end
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (hready_o !== 1'b1) begin errors++; $display("FAIL post_reset_hready: got %b need 1", hready_o); end
  endtask

  task automatic test_forwarding();
    act = 0;
    drive_addr(32'h10, 1'b1, 3'd2);
    step();
    drive_addr(32'h10, 1'b0, 3'd2);
    hwdata_d = 32'hDEADBEEF;
    checks++; if (hready_o !== 1'b1) begin errors++; $display("FAIL fwd_write_dphase_hready: got %b need 1", hready_o); end
    step();
    drive_idle();
    checks++; if (hready_o !== 1'b1) begin errors++; $display("FAIL fwd_read_hready: got %b need 1", hready_o); end
    checks++; if (hrdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_read_data: got %h need deadbeef", hrdata_o); end
    checks++; if (hresp_o !== 3'd0) begin errors++; $display("FAIL fwd_read_hresp: got %0d need 0", hresp_o); end
    step();
    checks++; if (hrdata_o !== 32'h0) begin errors++; $display("FAIL fwd_idle_hrdata: got %h need 0", hrdata_o); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d; logic [2:0] r; int w;
    act = 0;
    do_write(32'h13, 3'd0, 32'hAA000000);
    do_read(32'h10, 3'd2, d, r, w);
    checks++; if (d !== 32'hAAADBEEF) begin errors++; $display("FAIL byte_write_0x13: got %h need aaadbeef", d); end
    do_write(32'h40, 3'd2, 32'h11223344);
    do_write(32'h42, 3'd1, 32'hCAFE0000);
    do_read(32'h40, 3'd2, d, r, w);
    checks++; if (d !== 32'hCAFE3344) begin errors++; $display("FAIL half_write_0x42: got %h need cafe3344", d); end
    do_write(32'h41, 3'd0, 32'h00007700);
    do_read(32'h40, 3'd2, d, r, w);
    checks++; if (d !== 32'hCAFE7744) begin errors++; $display("FAIL byte_write_0x41: got %h need cafe7744", d); end
    do_read(32'h42, 3'd1, d, r, w);
    checks++; if (d !== 32'hCAFE7744) begin errors++; $display("FAIL half_read_0x42: got %h need cafe7744", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [2:0] r; int w;
    act = 0;
    drive_addr(32'h50, 1'b1, 3'd2);
    step();
    drive_addr(32'h54, 1'b1, 3'd2);
    hwdata_d = 32'hA5A5_0001;
    step();
    drive_addr(32'h50, 1'b0, 3'd2);
    hwdata_d = 32'h5A5A_0002;
    step();
    drive_idle();
    checks++; if (hready_o !== 1'b1) begin errors++; $display("FAIL b2b_hready: got %b need 1", hready_o); end
    checks++; if (hrdata_o !== 32'hA5A50001) begin errors++; $display("FAIL b2b_wwr_data: got %h need a5a50001", hrdata_o); end
    step();
    do_read(32'h54, 3'd2, d, r, w);
    checks++; if (d !== 32'h5A5A0002) begin errors++; $display("FAIL b2b_second_word: got %h need 5a5a0002", d); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic [2:0] r; int w;
    act = 0;
    drive_addr(32'h11, 1'b1, 3'd1);
    step();
    drive_idle();
    hwdata_d = 32'h00555500;
`ifdef AHB_LITE_SRAM_ERR_EN
    checks++; if (hready_o !== 1'b0 || hresp_o !== 3'd1) begin errors++; $display("FAIL err1: got ready=%b resp=%0d need ready=0 resp=1", hready_o, hresp_o); end
    step();
    checks++; if (hready_o !== 1'b1 || hresp_o !== 3'd1) begin errors++; $display("FAIL err2: got ready=%b resp=%0d need ready=1 resp=1", hready_o, hresp_o); end
    step();
    checks++; if (hresp_o !== 3'd0) begin errors++; $display("FAIL err_after: got resp=%0d need 0", hresp_o); end
`else
    checks++; if (hready_o !== 1'b1 || hresp_o !== 3'd0) begin errors++; $display("FAIL illegal_okay: got ready=%b resp=%0d need ready=1 resp=0", hready_o, hresp_o); end
    step();
`endif
    do_read(32'h10, 3'd2, d, r, w);
    checks++; if (d !== 32'hAAADBEEF) begin errors++; $display("FAIL illegal_write_kept: got %h need aaadbeef", d); end
    do_read(32'h1000, 3'd2, d, r, w);
`ifdef AHB_LITE_SRAM_ERR_EN
    checks++; if (d !== 32'h0 || r !== 3'd1 || w != 1) begin errors++; $display("FAIL oob_read: got d=%h r=%0d w=%0d need 0/1/1", d, r, w); end
`else
    checks++; if (d !== 32'h0 || r !== 3'd0 || w != 0) begin errors++; $display("FAIL oob_read: got d=%h r=%0d w=%0d need 0/0/0", d, r, w); end
`endif
    do_read(32'h10, 3'd3, d, r, w);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL dword_read_on_32bit: got %h need 0", d); end
  endtask

  task automatic test_wait_states();
    act = 2;
    do_write(32'h10, 3'd2, 32'h0BADF00D);
    drive_addr(32'h10, 1'b0, 3'd2);
    step();
    drive_idle();
    checks++; if (hready_o !== 1'b0 || hresp_o !== 3'd0) begin errors++; $display("FAIL ws_cycle1: got ready=%b resp=%0d need 0/0", hready_o, hresp_o); end
    step();
    checks++; if (hready_o !== 1'b0 || hresp_o !== 3'd0) begin errors++; $display("FAIL ws_cycle2: got ready=%b resp=%0d need 0/0", hready_o, hresp_o); end
    step();
    checks++; if (hready_o !== 1'b1 || hresp_o !== 3'd0) begin errors++; $display("FAIL ws_done: got ready=%b resp=%0d need 1/0", hready_o, hresp_o); end
    checks++; if (hrdata_o !== 32'h0BADF00D) begin errors++; $display("FAIL ws_data: got %h need 0badf00d", hrdata_o); end
    step();
  endtask

  task automatic test_async_reset();
    act = 2;
    drive_addr(32'h10, 1'b0, 3'd2);
    step();
    drive_idle();
    checks++; if (hready_o !== 1'b0) begin errors++; $display("FAIL arst_pre_wait: got %b need 0", hready_o); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (hready_o !== 1'b1 || hresp_o !== 3'd0 || hrdata_o !== 32'h0) begin errors++; $display("FAIL arst_immediate: got ready=%b resp=%0d data=%h need 1/0/0", hready_o, hresp_o, hrdata_o); end
    step(); step();
    checks++; if (hready_o !== 1'b1 || hrdata_o !== 32'h0) begin errors++; $display("FAIL arst_held: got ready=%b data=%h need 1/0", hready_o, hrdata_o); end
    rst = 1'b0;
    step();
    checks++; if (hready_o !== 1'b1) begin errors++; $display("FAIL arst_release: got %b need 1", hready_o); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic [2:0] r; int w;
    act = 3;
    do_write(32'h20, 3'd2, 32'hCAFEF00D);
    do_read(32'h20, 3'd2, d, r, w);
    checks++; if (d !== 32'hCAFEF00D || w != 3) begin errors++; $display("FAIL abort_setup: got d=%h w=%0d need cafef00d/3", d, w); end
    step(); step();
    drive_addr(32'h20, 1'b1, 3'd2);
    step();
    drive_idle();
    hwdata_d = 32'h12345678;
    checks++; if (hready_o !== 1'b0) begin errors++; $display("FAIL abort_in_wait: got %b need 0", hready_o); end
    step();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (hready_o !== 1'b1) begin errors++; $display("FAIL abort_reset_ready: got %b need 1", hready_o); end
    step();
    rst = 1'b0;
    step();
    do_read(32'h20, 3'd2, d, r, w);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_discarded: got %h need cafef00d", d); end
    checks++; if (r !== 3'd0 || w != 3) begin errors++; $display("FAIL abort_read_timing: got r=%0d w=%0d need 0/3", r, w); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_byte_lanes();
    test_back_to_back();
    test_illegal();
    test_wait_states();
    test_async_reset();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
